// File: rtl/baud_gen_frac_pkg.sv
// Shared defaults for the fractional baud generator: oversample ratio,
// CSR field widths and the post-reset divisor (50 MHz -> 115200 baud x16).
package baud_gen_frac_pkg;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DIV_W_DEF      = 16;
    localparam int FRAC_W_DEF     = 4;
    localparam int DEF_DIV_INT    = 27;
    localparam int DEF_DIV_FRAC   = 2;
endpackage

// File: rtl/baud_gen_frac_prescaler.sv
// Fractional prescaler: integer clock counter plus a fractional accumulator whose
// carry stretches one period by a clock. Owns the shadow/active divisor pair.
module baud_gen_frac_prescaler #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int DEF_DIV_INT  = 27,
    parameter int DEF_DIV_FRAC = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              resync_i,
    input  logic              div_load_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              wrap_o,
    output logic              tick_o,
    output logic              cfg_err_o
);
    logic [DIV_W:0]    cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [DIV_W-1:0]  sh_int_q, sh_int_d, act_int_q, act_int_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d, act_frac_q, act_frac_d;
    logic              pend_q, pend_d;
    logic              tick_q, tick_d;

    logic [FRAC_W:0]   sum;
    logic [DIV_W-1:0]  int_eff;
    logic [DIV_W:0]    period_m1;
    logic              wrap;
    logic              apply;

    always_comb begin
        int_eff   = (act_int_q == '0) ? DIV_W'(1) : act_int_q;
        sum       = {1'b0, acc_q} + {1'b0, act_frac_q};
        period_m1 = {1'b0, int_eff} + (DIV_W+1)'(sum[FRAC_W]) - (DIV_W+1)'(1);
        // >= rather than == so a shorter divisor applied while stopped cannot strand cnt
        wrap      = enable_i && !resync_i && (cnt_q >= period_m1);
        apply     = (pend_q || div_load_i) && (resync_i || wrap || !enable_i);

        cnt_d      = cnt_q;
        acc_d      = acc_q;
        tick_d     = 1'b0;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        pend_d     = pend_q || div_load_i;

        if (div_load_i) begin
            sh_int_d  = div_int_i;
            sh_frac_d = div_frac_i;
        end
        // A strobe coincident with the switch point bypasses the shadow
        if (apply) begin
            act_int_d  = div_load_i ? div_int_i  : sh_int_q;
            act_frac_d = div_load_i ? div_frac_i : sh_frac_q;
            pend_d     = 1'b0;
        end

        if (resync_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (enable_i) begin
            if (wrap) begin
                cnt_d  = '0;
                acc_d  = sum[FRAC_W-1:0];
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + (DIV_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            sh_int_q   <= DIV_W'(DEF_DIV_INT);
            sh_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
            act_int_q  <= DIV_W'(DEF_DIV_INT);
            act_frac_q <= FRAC_W'(DEF_DIV_FRAC);
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
        end
    end

    assign wrap_o    = wrap;
    assign tick_o    = tick_q;
    assign cfg_err_o = (act_int_q == '0);
endmodule

// File: rtl/baud_gen_frac.sv
// UART baud generator top: counts oversample ticks into bit phase and decodes
// the registered mid-bit and end-of-bit strobes alongside the oversample tick.
module baud_gen_frac
    import baud_gen_frac_pkg::*;
#(
    parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
    parameter int DIV_W        = DIV_W_DEF,
    parameter int FRAC_W       = FRAC_W_DEF,
    parameter int DEF_DIV_INT  = baud_gen_frac_pkg::DEF_DIV_INT,
    parameter int DEF_DIV_FRAC = baud_gen_frac_pkg::DEF_DIV_FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              resync,
    output logic              oversample_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              cfg_err
);
    localparam int OS_W = $clog2(OVERSAMPLE);

    logic            wrap;
    logic [OS_W-1:0] os_cnt_q, os_cnt_d, os_next;
    logic            mid_q, mid_d;
    logic            bit_q, bit_d;

    baud_gen_frac_prescaler #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .DEF_DIV_INT  (DEF_DIV_INT),
        .DEF_DIV_FRAC (DEF_DIV_FRAC)
    ) u_prescaler (
        .clk_i      (clk),
        .reset_i    (reset),
        .enable_i   (enable),
        .resync_i   (resync),
        .div_load_i (div_load),
        .div_int_i  (div_int),
        .div_frac_i (div_frac),
        .wrap_o     (wrap),
        .tick_o     (oversample_tick),
        .cfg_err_o  (cfg_err)
    );

    // Decode from the post-wrap count so mid/bit land on the same edge as the tick
    always_comb begin
        os_next  = (os_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + OS_W'(1);
        os_cnt_d = os_cnt_q;
        mid_d    = 1'b0;
        bit_d    = 1'b0;
        if (resync) begin
            os_cnt_d = '0;
        end else if (wrap) begin
            os_cnt_d = os_next;
            mid_d    = (os_next == OS_W'(OVERSAMPLE / 2));
            bit_d    = (os_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            os_cnt_q <= '0;
            mid_q    <= 1'b0;
            bit_q    <= 1'b0;
        end else begin
            os_cnt_q <= os_cnt_d;
            mid_q    <= mid_d;
            bit_q    <= bit_d;
        end
    end

    assign mid_tick = mid_q;
    assign bit_tick = bit_q;
endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed scenarios plus a randomized run, every cycle
// compared against a period-length reference model built from floor arithmetic.
module tb_baud_gen_frac;
    localparam int OS = 16;
    localparam int DW = 16;
    localparam int FW = 4;
    localparam int FSCALE = 1 << FW;

    logic          clk = 1'b0;
    logic          reset, enable, div_load, resync;
    logic [DW-1:0] div_int;
    logic [FW-1:0] div_frac;
    logic          os_tick, mid_tick, bit_tick, cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    baud_gen_frac dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .div_int         (div_int),
        .div_frac        (div_frac),
        .div_load        (div_load),
        .resync          (resync),
        .oversample_tick (os_tick),
        .mid_tick        (mid_tick),
        .bit_tick        (bit_tick),
        .cfg_err         (cfg_err)
    );

    // Reference: the k-th period of a segment (fixed divisor, starting fraction a0)
    // ends at k*I + floor((a0 + k*f) / 2^FW) enabled edges.
    int m_int, m_frac, m_sh_int, m_sh_frac, m_acc0, m_k, m_since, m_os;
    bit m_pend, e_os, e_mid, e_bit;

    function automatic int ieff(input int i);
        return (i == 0) ? 1 : i;
    endfunction

    function automatic int period_len();
        int a;
        a = m_acc0 + m_k * m_frac;
        return ieff(m_int) + ((a + m_frac) / FSCALE - a / FSCALE);
    endfunction

    task automatic model_edge();
        bit tk, ap;
        if (reset) begin
            m_int = 27; m_frac = 2; m_sh_int = 27; m_sh_frac = 2; m_pend = 0;
            m_acc0 = 0; m_k = 0; m_since = 0; m_os = 0;
            e_os = 0; e_mid = 0; e_bit = 0;
        end else begin
            tk = enable && !resync && (m_since + 1 >= period_len());
            ap = (m_pend || div_load) && (resync || tk || !enable);
            e_os = tk; e_mid = 0; e_bit = 0;
            if (resync) begin
                m_since = 0; m_k = 0; m_acc0 = 0; m_os = 0;
            end else if (tk) begin
                m_since = 0; m_k++;
                m_os = (m_os + 1) % OS;
                e_mid = (m_os == OS / 2);
                e_bit = (m_os == 0);
            end else if (enable) begin
                m_since++;
            end
            if (ap) begin
                m_acc0 = (m_acc0 + m_k * m_frac) % FSCALE;
                m_k = 0;
                m_int  = div_load ? int'(div_int)  : m_sh_int;
                m_frac = div_load ? int'(div_frac) : m_sh_frac;
                m_pend = 0;
            end else if (div_load) begin
                m_pend = 1;
            end
            if (div_load) begin
                m_sh_int = int'(div_int);
                m_sh_frac = int'(div_frac);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("oversample_tick", 32'(os_tick), 32'(e_os));
        chk("mid_tick", 32'(mid_tick), 32'(e_mid));
        chk("bit_tick", 32'(bit_tick), 32'(e_bit));
        chk("cfg_err", 32'(cfg_err), 32'(m_int == 0));
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return os_tick;
            1:       return mid_tick;
            default: return bit_tick;
        endcase
    endfunction

    // Steps until the selected strobe is seen; n = edges taken.
    task automatic wait_ev(input int sel, input int max, input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sig(sel) !== 1'b1 && n < max);
        if (sig(sel) !== 1'b1) chk({tag, "_timeout"}, 32'(sig(sel)), 32'd1);
    endtask

    task automatic load(input int i, input int f);
        div_int = DW'(i); div_frac = FW'(f); div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    initial begin
        int n, n2, total, quiet;
        int per[16];

        reset = 1'b1; enable = 1'b0; div_load = 1'b0; resync = 1'b0;
        div_int = '0; div_frac = '0;
        repeat (3) step();
        chk("reset_os_tick", 32'(os_tick), 32'd0);
        chk("reset_cfg_err", 32'(cfg_err), 32'd0);
        reset = 1'b0;

        // 27/0 loaded while stopped goes active at once
        load(27, 0);
        enable = 1'b1;
        wait_ev(0, 100, "t1_first", n);
        chk("t1_first_period", n, 27);
        wait_ev(1, 400, "t1_mid", n2);
        chk("t1_mid_at", n + n2, 216);
        wait_ev(2, 400, "t1_bit", n);
        chk("t1_bit_at", 216 + n, 432);
        wait_ev(2, 600, "t1_bit2", n);
        chk("t1_bit_period", n, 432);

        // Defaults 27 + 2/16: the 8th and 16th periods stretch to 28
        reset = 1'b1; enable = 1'b0;
        repeat (2) step();
        reset = 1'b0; enable = 1'b1;
        total = 0;
        for (int i = 0; i < 16; i++) begin
            wait_ev(0, 100, "t2_period", per[i]);
            total += per[i];
        end
        chk("t2_period1", per[0], 27);
        chk("t2_period8", per[7], 28);
        chk("t2_period9", per[8], 27);
        chk("t2_period16", per[15], 28);
        chk("t2_total", total, 434);
        chk("t2_bit_on_16th", 32'(bit_tick), 32'd1);

        // resync mid-bit with 27/0 active
        load(27, 0);
        wait_ev(0, 100, "t3_apply", n);
        wait_ev(2, 600, "t3_bit", n);
        for (int i = 0; i < 5; i++) wait_ev(0, 100, "t3_os", n);
        repeat (10) step();
        resync = 1'b1;
        step();
        chk("t3_no_tick_on_resync", 32'(os_tick), 32'd0);
        resync = 1'b0;
        wait_ev(0, 100, "t3_after", n);
        chk("t3_first_after_resync", n, 27);
        wait_ev(2, 600, "t3_bit_after", n2);
        chk("t3_bit_after_resync", n + n2, 432);

        // Load 13/0 five clocks into a period: old period still completes at 27
        repeat (5) step();
        load(13, 0);
        wait_ev(0, 100, "t4_end", n);
        chk("t4_old_period", 6 + n, 27);
        wait_ev(0, 100, "t4_new1", n);
        chk("t4_new_period1", n, 13);
        wait_ev(0, 100, "t4_new2", n);
        chk("t4_new_period2", n, 13);

        // Illegal zero divisor clamps to one clock per tick
        load(0, 0);
        wait_ev(0, 100, "t5_apply", n);
        chk("t5_cfg_err_set", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_every_clk", 32'(os_tick), 32'd1);
        end
        load(27, 0);
        chk("t5_cfg_err_clear", 32'(cfg_err), 32'd0);
        wait_ev(0, 100, "t5_after", n);
        chk("t5_period_after", n, 27);

        // Pause for 100 clocks mid-period; phase must resume exactly
        repeat (10) step();
        enable = 1'b0;
        quiet = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (os_tick || mid_tick || bit_tick) quiet++;
        end
        chk("t6_pause_quiet", quiet, 0);
        enable = 1'b1;
        wait_ev(0, 100, "t6_resume", n);
        chk("t6_resume_phase", 10 + n, 27);

        // Reset mid-bit with an illegal divisor active
        load(0, 0);
        repeat (40) step();
        reset = 1'b1;
        step();
        chk("t6_reset_os", 32'(os_tick), 32'd0);
        chk("t6_reset_mid", 32'(mid_tick), 32'd0);
        chk("t6_reset_bit", 32'(bit_tick), 32'd0);
        chk("t6_reset_cfg_err", 32'(cfg_err), 32'd0);
        reset = 1'b0;
        wait_ev(0, 100, "t6_default", n);
        chk("t6_default_period", n, 27);

        // Randomized run with small divisors against the model
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 1499) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            resync   = ($urandom_range(0, 249) == 0);
            div_load = ($urandom_range(0, 59) == 0);
            div_int  = DW'($urandom_range(0, 6));
            div_frac = FW'($urandom_range(0, FSCALE - 1));
            step();
        end
        reset = 1'b0; resync = 1'b0; div_load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
